// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NREG      = 32;

  localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

  // Stall holds PC and IF/ID; bubble zeroes ID/EX control bits.
  typedef struct packed {
    logic stall;
    logic bubble;
  } pipe_ctrl_t;

  // True when a used source operand names the given destination.
  function automatic logic src_match(input logic                 used,
                                     input logic [REG_IDX_W-1:0] rs,
                                     input logic [REG_IDX_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/WB-side signal bundle for the hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = 32
) ();

  logic                 id_valid_i;
  logic [REG_IDX_W-1:0] id_rs1_i;
  logic [REG_IDX_W-1:0] id_rs2_i;
  logic                 id_rs1_used_i;
  logic                 id_rs2_used_i;
  logic [REG_IDX_W-1:0] id_rd_i;
  logic                 id_regwrite_i;
  logic                 id_memread_i;
  logic                 flush_i;
  logic                 mem_stall_i;
  logic                 wb_valid_i;
  logic [REG_IDX_W-1:0] wb_rd_i;
  logic                 wb_regwrite_i;
  logic                 stall_o;
  logic                 bubble_o;
  logic [NREG-1:0]      pending_o;
  logic                 err_o;

  // Pipeline side: drives decode/retire information, consumes controls.
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
    output id_rd_i, id_regwrite_i, id_memread_i, flush_i, mem_stall_i,
    output wb_valid_i, wb_rd_i, wb_regwrite_i,
    input  stall_o, bubble_o, pending_o, err_o
  );

  // Scoreboard side.
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
    input  id_rd_i, id_regwrite_i, id_memread_i, flush_i, mem_stall_i,
    input  wb_valid_i, wb_rd_i, wb_regwrite_i,
    output stall_o, bubble_o, pending_o, err_o
  );

endinterface

// File: rtl/hazard_scoreboard_counter.sv
// Saturating up/down in-flight writer counter for one register.
module scoreboard_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic ovf_o,
  output logic unf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc/dec cancel; saturate at both ends and flag it.
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CNT_MAX) ovf_o = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
      2'b01: begin
        if (cnt_q == '0) unf_o = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector and in-flight writer scoreboard for the ID stage.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_scoreboard_if.slave sb
);

  logic [REG_IDX_W-1:0] ex_rd_q, ex_rd_d;
  logic                 ex_load_q, ex_load_d;
  logic                 err_q, err_d;
  logic                 hazard;
  logic                 issue;
  pipe_ctrl_t           ctrl;

  logic [NREG-1:1]      inc_v, dec_v, nz_v, ovf_v, unf_v;

  // Load in EXE feeding a source read in ID cannot be forwarded in time.
  always_comb begin
    hazard = sb.id_valid_i && ex_load_q && (ex_rd_q != X0) &&
             (src_match(sb.id_rs1_used_i, sb.id_rs1_i, ex_rd_q) ||
              src_match(sb.id_rs2_used_i, sb.id_rs2_i, ex_rd_q));
    issue  = sb.id_valid_i && !hazard && !sb.flush_i && !sb.mem_stall_i;
    // Flush squashes the ID instruction so it no longer stalls; a freeze never bubbles.
    ctrl.stall  = !rst_i && ((hazard && !sb.flush_i) || sb.mem_stall_i);
    ctrl.bubble = !rst_i && !sb.mem_stall_i && (hazard || sb.flush_i);
  end

  // EXE occupant: hold on freeze, take the issued instruction, else a bubble.
  always_comb begin
    ex_rd_d   = ex_rd_q;
    ex_load_d = ex_load_q;
    if (!sb.mem_stall_i) begin
      if (issue) begin
        ex_rd_d   = sb.id_rd_i;
        ex_load_d = sb.id_memread_i && sb.id_regwrite_i;
      end else begin
        ex_rd_d   = X0;
        ex_load_d = 1'b0;
      end
    end
  end

  // Per-register increment on issue and decrement on retirement; x0 excluded.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc_v[r] = issue && sb.id_regwrite_i && (sb.id_rd_i == REG_IDX_W'(r));
      dec_v[r] = sb.wb_valid_i && sb.wb_regwrite_i && (sb.wb_rd_i == REG_IDX_W'(r));
    end
  end

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (inc_v[g]),
      .dec_i     (dec_v[g]),
      .nonzero_o (nz_v[g]),
      .ovf_o     (ovf_v[g]),
      .unf_o     (unf_v[g])
    );
  end

  // Sticky error: any counter saturating in either direction.
  always_comb begin
    err_d = err_q || (|ovf_v) || (|unf_v);
  end

  // EXE tracking and error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rd_q   <= X0;
      ex_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ex_rd_q   <= ex_rd_d;
      ex_load_q <= ex_load_d;
      err_q     <= err_d;
    end
  end

  assign sb.stall_o   = ctrl.stall;
  assign sb.bubble_o  = ctrl.bubble;
  assign sb.pending_o = rst_i ? '0 : {nz_v, 1'b0};
  assign sb.err_o     = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a multiset-based reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NR)) sb();

  hazard_scoreboard #(.NREG(NR), .CNT_W(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: destinations of every instruction between issue and
  // retirement, plus the instruction occupying EXE.
  int unsigned inflight[$];
  int unsigned m_ex_rd   = 0;
  bit          m_ex_load = 1'b0;
  bit          m_err     = 1'b0;

  function automatic int unsigned writers(input int unsigned r);
    int unsigned n = 0;
    foreach (inflight[i]) if (inflight[i] == r) n++;
    return n;
  endfunction

  function automatic bit model_hazard();
    bit reads;
    reads = (sb.id_rs1_used_i && 32'(sb.id_rs1_i) == m_ex_rd) ||
            (sb.id_rs2_used_i && 32'(sb.id_rs2_i) == m_ex_rd);
    return sb.id_valid_i && m_ex_load && (m_ex_rd != 0) && reads;
  endfunction

  // Compare every cycle at the falling edge, then advance the model.
  initial begin
    bit             haz, iss, found;
    int unsigned    inc_r, dec_r;
    logic [NR-1:0]  e_pend;
    @(posedge clk);
    forever begin
      @(negedge clk);
      haz    = model_hazard();
      e_pend = '0;
      if (!rst) for (int r = 1; r < NR; r++) e_pend[r] = (writers(r) != 0);
      check("stall",   32'(sb.stall_o),  rst ? 32'd0 : 32'((haz && !sb.flush_i) || sb.mem_stall_i));
      check("bubble",  32'(sb.bubble_o), rst ? 32'd0 : 32'(!sb.mem_stall_i && (haz || sb.flush_i)));
      check("pending", sb.pending_o, e_pend);
      check("err",     32'(sb.err_o), 32'(m_err));
      if (rst) begin
        inflight.delete();
        m_ex_rd   = 0;
        m_ex_load = 1'b0;
        m_err     = 1'b0;
      end else begin
        iss   = sb.id_valid_i && !haz && !sb.flush_i && !sb.mem_stall_i;
        inc_r = (iss && sb.id_regwrite_i) ? 32'(sb.id_rd_i) : 0;
        dec_r = (sb.wb_valid_i && sb.wb_regwrite_i) ? 32'(sb.wb_rd_i) : 0;
        if (!(inc_r != 0 && inc_r == dec_r)) begin
          if (dec_r != 0) begin
            found = 1'b0;
            for (int i = 0; i < inflight.size(); i++) begin
              if (!found && inflight[i] == dec_r) begin
                inflight.delete(i);
                found = 1'b1;
              end
            end
            if (!found) m_err = 1'b1;
          end
          if (inc_r != 0) begin
            if (writers(inc_r) >= 3) m_err = 1'b1;
            else inflight.push_back(inc_r);
          end
        end
        if (!sb.mem_stall_i) begin
          m_ex_rd   = iss ? 32'(sb.id_rd_i) : 0;
          m_ex_load = iss && sb.id_memread_i && sb.id_regwrite_i;
        end
      end
    end
  end

  task automatic set_id(input bit v, input int unsigned rd, input bit rw, input bit mr,
                        input int unsigned rs1, input bit u1,
                        input int unsigned rs2, input bit u2);
    sb.id_valid_i    = v;
    sb.id_rd_i       = 5'(rd);
    sb.id_regwrite_i = rw;
    sb.id_memread_i  = mr;
    sb.id_rs1_i      = 5'(rs1);
    sb.id_rs1_used_i = u1;
    sb.id_rs2_i      = 5'(rs2);
    sb.id_rs2_used_i = u2;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic set_wb(input bit v, input int unsigned rd);
    sb.wb_valid_i    = v;
    sb.wb_regwrite_i = v;
    sb.wb_rd_i       = 5'(rd);
  endtask

  task automatic obs();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    nop();
    set_wb(1'b0, 0);
    sb.flush_i     = 1'b0;
    sb.mem_stall_i = 1'b0;
    obs();
    check("rst_stall",   32'(sb.stall_o),  32'd0);
    check("rst_bubble",  32'(sb.bubble_o), 32'd0);
    check("rst_pending", sb.pending_o,     32'd0);
    nxt();
    rst = 1'b0;
    obs();
    check("rst_err", 32'(sb.err_o), 32'd0);
    nxt();

    // Load-use: lw x5 then add x6,x5,x1 stalls exactly one cycle.
    set_id(1'b1, 5, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
    obs(); check("lu_lw_nostall", 32'(sb.stall_o), 32'd0); nxt();
    set_id(1'b1, 6, 1'b1, 1'b0, 5, 1'b1, 1, 1'b1);
    obs(); check("lu_stall", 32'(sb.stall_o), 32'd1); check("lu_bubble", 32'(sb.bubble_o), 32'd1); nxt();
    obs(); check("lu_release", 32'(sb.stall_o), 32'd0); check("lu_no_bubble", 32'(sb.bubble_o), 32'd0); nxt();
    nop(); set_wb(1'b1, 5);
    obs(); check("lu_pend5", 32'(sb.pending_o[5]), 32'd1); check("lu_pend6", 32'(sb.pending_o[6]), 32'd1); nxt();
    set_wb(1'b1, 6);
    obs(); check("lu_pend5_clr", 32'(sb.pending_o[5]), 32'd0); nxt();
    set_wb(1'b0, 0);

    // ALU dependency: add x5 then sub x7,x5,x2 never stalls.
    set_id(1'b1, 5, 1'b1, 1'b0, 1, 1'b1, 2, 1'b1);
    obs(); check("alu_first", 32'(sb.stall_o), 32'd0); nxt();
    set_id(1'b1, 7, 1'b1, 1'b0, 5, 1'b1, 2, 1'b1);
    obs(); check("alu_nostall", 32'(sb.stall_o), 32'd0); check("alu_pend5", 32'(sb.pending_o[5]), 32'd1); nxt();
    nop(); set_wb(1'b1, 5);
    obs(); check("alu_pend5_wb", 32'(sb.pending_o[5]), 32'd1); nxt();
    set_wb(1'b1, 7);
    obs(); check("alu_pend5_clr", 32'(sb.pending_o[5]), 32'd0); nxt();
    set_wb(1'b0, 0);

    // lw x0 then add x1,x0,x0: x0 is never a hazard nor tracked.
    set_id(1'b1, 0, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
    nxt();
    set_id(1'b1, 1, 1'b1, 1'b0, 0, 1'b1, 0, 1'b1);
    obs(); check("x0_nostall", 32'(sb.stall_o), 32'd0); check("x0_pending", sb.pending_o, 32'd0); nxt();
    nop(); set_wb(1'b1, 0); nxt();
    set_wb(1'b1, 1); nxt();
    set_wb(1'b0, 0);

    // lw x5 then lui x5 (no sources used): no stall, two writers.
    set_id(1'b1, 5, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
    nxt();
    set_id(1'b1, 5, 1'b1, 1'b0, 5, 1'b0, 5, 1'b0);
    obs(); check("lui_nostall", 32'(sb.stall_o), 32'd0); nxt();
    nop(); set_wb(1'b1, 5); nxt();
    set_wb(1'b1, 5);
    obs(); check("lui_pend5_one_left", 32'(sb.pending_o[5]), 32'd1); nxt();
    set_wb(1'b0, 0);
    obs(); check("lui_pend5_clr", 32'(sb.pending_o[5]), 32'd0); nxt();

    // Flush beats hazard; no residual stall afterwards.
    set_id(1'b1, 8, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
    nxt();
    set_id(1'b1, 9, 1'b1, 1'b0, 8, 1'b1, 8, 1'b1);
    sb.flush_i = 1'b1;
    obs(); check("fl_stall", 32'(sb.stall_o), 32'd0); check("fl_bubble", 32'(sb.bubble_o), 32'd1); nxt();
    sb.flush_i = 1'b0;
    obs(); check("fl_after_stall", 32'(sb.stall_o), 32'd0); check("fl_after_bubble", 32'(sb.bubble_o), 32'd0); nxt();
    nop(); set_wb(1'b1, 8); nxt();
    set_wb(1'b1, 9); nxt();
    set_wb(1'b0, 0);

    // Memory freeze across a load-use pair.
    set_id(1'b1, 10, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
    nxt();
    set_id(1'b1, 11, 1'b1, 1'b0, 10, 1'b1, 1, 1'b1);
    sb.mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      obs(); check("ms_stall", 32'(sb.stall_o), 32'd1); check("ms_no_bubble", 32'(sb.bubble_o), 32'd0); nxt();
    end
    sb.mem_stall_i = 1'b0;
    obs(); check("ms_hazard_stall", 32'(sb.stall_o), 32'd1); check("ms_hazard_bubble", 32'(sb.bubble_o), 32'd1); nxt();
    obs(); check("ms_resolved", 32'(sb.stall_o), 32'd0); nxt();
    nop(); set_wb(1'b1, 10); nxt();
    set_wb(1'b1, 11); nxt();
    set_wb(1'b0, 0);

    // Counter saturation on x9.
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 9, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      nxt();
    end
    nop();
    obs(); check("cnt_pend9", 32'(sb.pending_o[9]), 32'd1); check("cnt_err0", 32'(sb.err_o), 32'd0); nxt();
    set_id(1'b1, 9, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    set_wb(1'b1, 9);
    nxt();
    set_wb(1'b0, 0);
    obs(); check("cnt_incdec_err0", 32'(sb.err_o), 32'd0); nxt();
    nop();
    obs(); check("cnt_ovf_err", 32'(sb.err_o), 32'd1); nxt();
    obs(); check("cnt_err_sticky", 32'(sb.err_o), 32'd1); nxt();
    rst = 1'b1;
    obs(); check("cnt_rst_pending_forced", sb.pending_o, 32'd0); nxt();
    rst = 1'b0;
    obs(); check("cnt_rst_err", 32'(sb.err_o), 32'd0); check("cnt_rst_pending", sb.pending_o, 32'd0); nxt();

    // Retirement of an untracked register underflows.
    set_wb(1'b1, 12); nxt();
    set_wb(1'b0, 0);
    obs(); check("unf_err", 32'(sb.err_o), 32'd1); nxt();

    // Reset in the middle of a load-use stall drops the hazard at once.
    set_id(1'b1, 5, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
    nxt();
    set_id(1'b1, 6, 1'b1, 1'b0, 5, 1'b1, 0, 1'b0);
    obs(); check("rs_pre_stall", 32'(sb.stall_o), 32'd1);
    nxt();
    set_id(1'b1, 6, 1'b1, 1'b0, 5, 1'b1, 0, 1'b0);
    nxt();
    set_id(1'b1, 5, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0);
    nxt();
    set_id(1'b1, 6, 1'b1, 1'b0, 5, 1'b1, 0, 1'b0);
    rst = 1'b1;
    obs(); check("rs_stall_forced", 32'(sb.stall_o), 32'd0); check("rs_bubble_forced", 32'(sb.bubble_o), 32'd0); nxt();
    rst = 1'b0;
    obs(); check("rs_no_residual", 32'(sb.stall_o), 32'd0); check("rs_err_clr", 32'(sb.err_o), 32'd0); nxt();
    nop();
    nxt();
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
